// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    cnt_t        out_cnt_reg, out_cnt_next;
    cnt_t        drop_cnt_reg, drop_cnt_next;
    cnt_t        fifo_cnt_reg, fifo_cnt_next;
    ptr_t        fifo_wr_reg, fifo_wr_next, fifo_rd_reg, fifo_rd_next;
    ptr_t        rq_wr_reg, rq_wr_next, rq_rd_reg, rq_rd_next;
    cnt_t        drop_redirect;

    logic [31:0] fifo_ins_mem [BUF_DEPTH];
    logic [31:0] fifo_pc_mem  [BUF_DEPTH];
    logic [31:0] rq_pc_mem    [BUF_DEPTH];

    logic credit_ok, req_fire, rsp_drop, push, pop;
    logic unused_redirect_bits;

    assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

    // Slots in flight plus slots held must stay below depth, so every response has a home.
    assign credit_ok      = ({1'b0, fifo_cnt_reg} + {1'b0, out_cnt_reg}) < DEPTH_W;
    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid  = (fifo_cnt_reg != '0);
    assign instruction = inst_valid ? fifo_ins_mem[fifo_rd_reg] : 32'h0;
    assign inst_pc     = inst_valid ? fifo_pc_mem[fifo_rd_reg]  : 32'h0;

    assign push = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    // A response landing in the redirect cycle is already gone, so it is not counted as stale.
    assign drop_redirect = (imem_rsp_valid && out_cnt_reg != '0) ? out_cnt_reg - 1'b1 : out_cnt_reg;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = (drop_redirect != '0) ? DRAIN : RUN;
        end else if (state_reg == DRAIN && imem_rsp_valid && drop_cnt_reg == cnt_t'(1)) begin
            state_next = RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        rsp_drop = (state_reg == DRAIN);
    end

    always_comb begin
        pc_next       = pc_reg;
        out_cnt_next  = out_cnt_reg + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
        drop_cnt_next = drop_cnt_reg;
        fifo_cnt_next = fifo_cnt_reg;
        fifo_wr_next  = fifo_wr_reg;
        fifo_rd_next  = fifo_rd_reg;
        rq_wr_next    = rq_wr_reg;
        rq_rd_next    = rq_rd_reg;

        if (req_fire) begin
            pc_next    = pc_reg + 32'd4;
            rq_wr_next = rq_wr_reg + 1'b1;
        end
        if (imem_rsp_valid) begin
            rq_rd_next = rq_rd_reg + 1'b1;
        end

        if (redirect_valid) begin
            pc_next       = {redirect_pc[31:2], 2'b00};
            drop_cnt_next = drop_redirect;
            fifo_cnt_next = '0;
            fifo_wr_next  = '0;
            fifo_rd_next  = '0;
        end else begin
            if (imem_rsp_valid && rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - 1'b1;
            end
            if (push) begin
                fifo_wr_next = fifo_wr_reg + 1'b1;
            end
            if (pop) begin
                fifo_rd_next = fifo_rd_reg + 1'b1;
            end
            fifo_cnt_next = fifo_cnt_reg + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            out_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            fifo_cnt_reg <= '0;
            fifo_wr_reg  <= '0;
            fifo_rd_reg  <= '0;
            rq_wr_reg    <= '0;
            rq_rd_reg    <= '0;
        end else begin
            pc_reg       <= pc_next;
            out_cnt_reg  <= out_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
            fifo_cnt_reg <= fifo_cnt_next;
            fifo_wr_reg  <= fifo_wr_next;
            fifo_rd_reg  <= fifo_rd_next;
            rq_wr_reg    <= rq_wr_next;
            rq_rd_reg    <= rq_rd_next;
        end
    end

    // Storage needs no reset: occupancy counters decide what is visible.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            rq_pc_mem[rq_wr_reg] <= pc_reg;
        end
        if (push) begin
            fifo_ins_mem[fifo_wr_reg] <= imem_rsp_data;
            fifo_pc_mem[fifo_wr_reg]  <= rq_pc_mem[rq_rd_reg];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (req_fire) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!inst_valid && inst_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
